mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF stage (read-only fetch) and the
//  MEM stage (load/store). Serialises requests with a small FSM and returns read data or a

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF fetch and MEM load/store.
// Define ARB_FAIRNESS_EN to let fetch win after DATA_STREAK_MAX back-to-back data grants.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LAT         = 1,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              sel_d_q, sel_d_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic              fetch_turn, pick_if, turnaround;

`ifdef ARB_FAIRNESS_EN
    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    logic [SW-1:0] streak_q, streak_d;
    assign fetch_turn = (streak_q == SW'(DATA_STREAK_MAX));
    always_comb streak_d = (~if_req | if_gnt_q) ? '0 :
                           (d_gnt_q & ~fetch_turn) ? streak_q + SW'(1) : streak_q;
    always_ff @(posedge clk) begin
        if (rst) streak_q <= '0;
        else     streak_q <= streak_d;
    end
`else
    assign fetch_turn = 1'b0;
`endif

    // The rvalid cycle is a turnaround: nothing is sampled, so a held req starts fresh next cycle.
    assign turnaround = if_rvalid_q | d_rvalid_q;
    assign pick_if    = if_req & (~d_req | fetch_turn);

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        sel_d_d     = sel_d_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: if (~turnaround & (if_req | d_req)) begin
                state_d     = ISSUE;
                sel_d_d     = ~pick_if;
                mem_req_d   = 1'b1;
                if_gnt_d    = pick_if;
                d_gnt_d     = ~pick_if;
                mem_we_d    = ~pick_if & d_we;
                mem_addr_d  = pick_if ? if_addr : d_addr;
                mem_wdata_d = pick_if ? mem_wdata_q : d_wdata;
            end
            ISSUE: begin
                state_d = WAIT;
                lat_d   = LAT_W'(MEM_LAT - 1);
            end
            WAIT: if (lat_q == '0) begin
                state_d     = IDLE;
                if_rvalid_d = ~sel_d_q;
                d_rvalid_d  = sel_d_q;
                if_rdata_d  = sel_d_q ? if_rdata_q : mem_rdata;
                d_rdata_d   = sel_d_q ? mem_rdata : d_rdata_q;
            end else begin
                lat_d = lat_q - LAT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            sel_d_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            sel_d_q     <= sel_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req & ~if_rvalid_q;
    assign stall_mem = d_req & ~d_rvalid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a behavioural memory and
// a transaction-level arbitration model (honours ARB_FAIRNESS_EN when defined).
module tb_mem_port_arbiter;
    localparam int L    = 3;
    localparam int SMAX = 4;

    logic        clk = 0, rst = 1;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .DATA_STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct {
        int          g;
        int          v;
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;
    exp_t ifq[$], dq[$];

    logic [31:0] mem_arr[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] rd_sched[int];

    function automatic logic [31:0] dflt(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_1234;
    endfunction

    function automatic logic [31:0] rdm(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Behavioural single-port memory: read data appears exactly L cycles after mem_req.
    always @(negedge clk) begin
        if (mem_req) begin
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
            else rd_sched[cyc + L] = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
        end
    end
    always @(posedge clk) begin
        #1;
        if (rd_sched.exists(cyc)) begin
            mem_rdata = rd_sched[cyc];
            rd_sched.delete(cyc);
        end else mem_rdata = $urandom;
    end

    // Monitor: compares every cycle against the head of each port's expectation queue.
    bit rst_was = 0;
    int ifg_cnt = 0;
    always @(negedge clk) begin
        bit eg_i, ev_i, eg_d, ev_d;
        if (rst) rst_was = 1;
        else begin
            if (rst_was) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_gnts", {if_gnt, d_gnt}, 0);
                chk("rst_rvalids", {if_rvalid, d_rvalid}, 0);
                chk("rst_if_rdata", if_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
                rst_was = 0;
            end
            eg_i = ifq.size() > 0 && ifq[0].g == cyc;
            ev_i = ifq.size() > 0 && ifq[0].v == cyc;
            eg_d = dq.size() > 0 && dq[0].g == cyc;
            ev_d = dq.size() > 0 && dq[0].v == cyc;
            chk("mem_req", mem_req, eg_i | eg_d);
            chk("if_gnt", if_gnt, eg_i);
            chk("d_gnt", d_gnt, eg_d);
            chk("stall_if", stall_if, if_req & ~ev_i);
            chk("stall_mem", stall_mem, d_req & ~ev_d);
            if (if_gnt) ifg_cnt++;
            if (eg_i) begin
                chk("if_mem_addr", mem_addr, ifq[0].a);
                chk("if_mem_we", mem_we, 0);
            end
            if (eg_d) begin
                chk("d_mem_addr", mem_addr, dq[0].a);
                chk("d_mem_we", mem_we, dq[0].we);
                if (dq[0].we) chk("d_mem_wdata", mem_wdata, dq[0].wd);
            end
            chk("if_rvalid", if_rvalid, ev_i);
            chk("d_rvalid", d_rvalid, ev_d);
            if (ev_i) begin
                chk("if_rdata", if_rdata, ifq[0].rd);
                void'(ifq.pop_front());
            end
            if (ev_d) begin
                if (!dq[0].we) chk("d_rdata", d_rdata, dq[0].rd);
                void'(dq.pop_front());
            end
        end
    end

    // Driver + reference model state.
    int          p_if = 0, p_d = 0;
    bit          want_if = 0, want_d = 0, w_d_we = 0, do_rst = 1;
    logic [31:0] w_if_a = 0, w_d_a = 0, w_d_wd = 0;
    bit          if_busy = 0, d_busy = 0;
    int          next_free = 0, s = 0, gport = 0, m_ifg = 0;

    task automatic step();
        bit seen_if, seen_d, wd;
        int gnext;
        exp_t e;
        @(negedge clk);
        seen_if = if_rvalid;
        seen_d  = d_rvalid;
        @(posedge clk);
        #1;
        rst = do_rst;
        if (do_rst) begin
            if_busy = 0; d_busy = 0; if_req = 0; d_req = 0;
            ifq.delete(); dq.delete();
            s = 0; gport = 0; next_free = cyc + 1;
            return;
        end
        if (seen_if) if_busy = 0;
        if (seen_d) d_busy = 0;
        if (!if_busy && (want_if || $urandom_range(99) < p_if)) begin
            if_busy = 1;
            if_addr = want_if ? w_if_a : 32'h1000_0000 | ($urandom_range(255) << 2);
            want_if = 0;
        end
        if (!d_busy && (want_d || $urandom_range(99) < p_d)) begin
            d_busy  = 1;
            d_we    = want_d ? w_d_we : 1'($urandom_range(1));
            d_addr  = want_d ? w_d_a : 32'h100 + ($urandom_range(63) << 2);
            d_wdata = want_d ? w_d_wd : $urandom;
            want_d  = 0;
        end
        if_req = if_busy;
        d_req  = d_busy;
        // One access at a time: sampled in a free cycle, gnt next, rvalid L+2 later, free again after.
        gnext = 0;
        if (cyc >= next_free && (if_req || d_req)) begin
`ifdef ARB_FAIRNESS_EN
            wd = d_req && !(if_req && s == SMAX);
`else
            wd = d_req;
`endif
            e.g = cyc + 1;
            e.v = cyc + L + 2;
            if (wd) begin
                e.a = d_addr; e.we = d_we; e.wd = d_wdata;
                e.rd = d_we ? 32'h0 : rdm(d_addr);
                if (d_we) ref_mem[d_addr] = d_wdata;
                dq.push_back(e);
                gnext = 2;
            end else begin
                e.a = if_addr; e.we = 0; e.wd = 0; e.rd = rdm(if_addr);
                ifq.push_back(e);
                gnext = 1;
                m_ifg++;
            end
            next_free = cyc + L + 3;
        end
        if (!if_req || gport == 1) s = 0;
        else if (gport == 2 && s < SMAX) s++;
        gport = gnext;
    endtask

    task automatic drain();
        int n = 0;
        p_if = 0;
        p_d  = 0;
        while ((if_busy || d_busy || ifq.size() > 0 || dq.size() > 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_in_time", n < 300, 1);
    endtask

    initial begin
        int pi[4] = '{30, 80, 20, 60};
        int pd[4] = '{30, 20, 80, 60};
        int f0, m0;
        mem_arr[32'h10] = 32'h0050_0093;
        ref_mem[32'h10] = 32'h0050_0093;
        repeat (3) step();
        do_rst = 0;
        want_if = 1; w_if_a = 32'h10;
        step(); drain();
        want_d = 1; w_d_we = 1; w_d_a = 32'h20; w_d_wd = 32'hDEAD_BEEF;
        step(); drain();
        want_if = 1; w_if_a = 32'h1000_0040;
        want_d = 1; w_d_we = 0; w_d_a = 32'h20;
        step(); drain();
        for (int k = 0; k < 4; k++) begin
            p_if = pi[k];
            p_d  = pd[k];
            repeat (150) step();
            drain();
        end
        f0 = ifg_cnt;
        m0 = m_ifg;
        p_if = 100;
        p_d  = 100;
        repeat (100) step();
`ifdef ARB_FAIRNESS_EN
        chk("fetch_grants", ifg_cnt - f0, m_ifg - m0);
        chk("fetch_not_starved", (ifg_cnt - f0) > 0, 1);
`else
        chk("fetch_starved", ifg_cnt - f0, 0);
`endif
        drain();
        want_d = 1; w_d_we = 0; w_d_a = 32'h40;
        step();
        step();
        do_rst = 1;
        step();
        do_rst = 0;
        repeat (L + 4) step();
        want_d = 1; w_d_we = 0; w_d_a = 32'h20;
        want_if = 1; w_if_a = 32'h1000_0100;
        step(); drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
